// File: rtl/seq_detector_param.sv
// Runtime-configurable serial pattern detector with overlap / non-overlap modes.
// Optional saturating match counter enabled by defining SEQDET_MATCH_COUNT_EN.
module seq_detector_param #(
    parameter  int MAX_LEN = 8,
    parameter  int CNT_W   = 8,
    localparam int LW      = $clog2(MAX_LEN) + 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    input  logic               in_bit,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LW-1:0]      cfg_len,
    input  logic               cfg_overlap,
    output logic               match,
    output logic               armed
`ifdef SEQDET_MATCH_COUNT_EN
    ,
    output logic [CNT_W-1:0]   match_count
`endif
);

    typedef enum logic [1:0] {IDLE, FILL, ARMED} state_t;

    state_t             state, state_nx;
    logic [MAX_LEN-1:0] hist, hist_sh, hist_nx, pat;
    logic [LW-1:0]      len, fill, fill_inc, fill_nx;
    logic               ovl, consume, hit, match_nx, armed_nx;

    function automatic logic [LW-1:0] clamp_len(input logic [LW-1:0] l);
        if (l < LW'(2))
            return LW'(2);
        else if (l > LW'(MAX_LEN))
            return LW'(MAX_LEN);
        else
            return l;
    endfunction

    // Extra headroom bit lets len == MAX_LEN produce an all-ones mask.
    function automatic logic [MAX_LEN-1:0] len_mask(input logic [LW-1:0] l);
        logic [MAX_LEN:0] one_ext;
        one_ext = {{MAX_LEN{1'b0}}, 1'b1} << l;
        return MAX_LEN'(one_ext - {{MAX_LEN{1'b0}}, 1'b1});
    endfunction

    assign consume  = in_valid && !cfg_load && (state != IDLE);
    assign hist_sh  = (hist << 1) | {{(MAX_LEN-1){1'b0}}, in_bit};
    assign fill_inc = (fill >= len) ? len : fill + LW'(1);
    assign hit      = consume && (fill_inc >= len) &&
                      ((hist_sh & len_mask(len)) == (pat & len_mask(len)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (cfg_load)
            state_nx = FILL;
        else if (consume) begin
            if (hit && !ovl)
                state_nx = FILL;
            else if (fill_inc >= len)
                state_nx = ARMED;
            else
                state_nx = FILL;
        end
    end

    always_comb begin
        match_nx = hit;
        armed_nx = (state_nx == ARMED);
        fill_nx  = fill;
        hist_nx  = hist;
        if (cfg_load) begin
            fill_nx = '0;
            hist_nx = '0;
        end else if (consume) begin
            fill_nx = (hit && !ovl) ? '0 : fill_inc;
            hist_nx = hist_sh;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist  <= '0;
            fill  <= '0;
            pat   <= '0;
            len   <= LW'(MAX_LEN);
            ovl   <= 1'b1;
            match <= 1'b0;
            armed <= 1'b0;
        end else begin
            hist  <= hist_nx;
            fill  <= fill_nx;
            match <= match_nx;
            armed <= armed_nx;
            if (cfg_load) begin
                pat <= cfg_pattern;
                len <= clamp_len(cfg_len);
                ovl <= cfg_overlap;
            end
        end
    end

`ifdef SEQDET_MATCH_COUNT_EN
    // Survives cfg_load; only reset clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            match_count <= '0;
        else if (hit && (match_count != {CNT_W{1'b1}}))
            match_count <= match_count + CNT_W'(1);
    end
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param: directed scenarios plus randomized traffic
// checked against a queue-based model of the detection rules.
module tb_seq_detector_param;

    localparam int ML = 8;
    localparam int LW = $clog2(ML) + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_bit = 1'b0;
    logic          cfg_load = 1'b0;
    logic [ML-1:0] cfg_pattern = '0;
    logic [LW-1:0] cfg_len = '0;
    logic          cfg_overlap = 1'b0;
    logic          match, armed;
`ifdef SEQDET_MATCH_COUNT_EN
    logic [1:0]    match_count;
`endif

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    bit            m_cfg;
    int            m_len;
    logic [ML-1:0] m_pat;
    bit            m_ovl;
    bit            q[$];
    bit            exp_match, exp_armed;
    int            exp_cnt;

    seq_detector_param #(.MAX_LEN(ML), .CNT_W(2)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_bit(in_bit),
        .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
        .cfg_overlap(cfg_overlap), .match(match), .armed(armed)
`ifdef SEQDET_MATCH_COUNT_EN
        , .match_count(match_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_cfg = 0; q.delete(); m_len = ML; m_pat = '0; m_ovl = 1;
        exp_match = 0; exp_armed = 0; exp_cnt = 0;
    endtask

    task automatic model_edge();
        bit hit;
        if (cfg_load) begin
            m_cfg = 1;
            m_len = (cfg_len < 2) ? 2 : (cfg_len > ML) ? ML : int'(cfg_len);
            m_pat = cfg_pattern;
            m_ovl = cfg_overlap;
            q.delete();
            exp_match = 0;
        end else if (in_valid && m_cfg) begin
            q.push_back(in_bit);
            if (q.size() > ML) void'(q.pop_front());
            hit = (q.size() >= m_len);
            for (int i = 0; i < m_len; i++)
                if (hit && (q[q.size()-1-i] != m_pat[i])) hit = 0;
            exp_match = hit;
            if (hit && exp_cnt < 3) exp_cnt++;
            if (hit && !m_ovl) q.delete();
        end else begin
            exp_match = 0;
        end
        exp_armed = m_cfg && (q.size() >= m_len);
    endtask

    task automatic step(input logic v, input logic b, input logic ld);
        in_valid = v; in_bit = b; cfg_load = ld;
        model_edge();
        @(posedge clk); #1;
        in_valid = 0; cfg_load = 0;
    endtask

    task automatic load(input int len, input logic [ML-1:0] pat, input logic ovl);
        cfg_len = LW'(len); cfg_pattern = pat; cfg_overlap = ovl;
        step(0, 0, 1);
    endtask

    task automatic pulse_reset();
        #2 rst_n = 0; model_reset();
        @(posedge clk); #1 rst_n = 1;
    endtask

    task automatic test_reset();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if (match !== 1'b0 || armed !== 1'b0) begin
            n_err++; $display("FAIL reset: match=%b armed=%b, need 0 0", match, armed);
        end
`ifdef SEQDET_MATCH_COUNT_EN
        n_vec++;
        if (match_count !== 2'd0) begin
            n_err++; $display("FAIL reset_count: got %0d need 0", match_count);
        end
`endif
        rst_n = 1;
        // Unconfigured block must ignore traffic matching the reset pattern.
        for (int i = 0; i < 10; i++) begin
            step(1, 0, 0);
            n_vec++;
            if (match !== 1'b0 || armed !== 1'b0) begin
                n_err++; $display("FAIL idle bit%0d: match=%b armed=%b, need 0 0", i, match, armed);
            end
        end
    endtask

    task automatic test_overlap();
        logic [6:0] s = 7'b1101101, em = 7'b0001001, ea = 7'b0001111;
        load(4, 8'b1101, 1);
        for (int i = 0; i < 7; i++) begin
            step(1, s[6-i], 0);
            n_vec++;
            if (match !== em[6-i] || armed !== ea[6-i]) begin
                n_err++;
                $display("FAIL overlap bit%0d: match=%b armed=%b, need %b %b", i+1, match, armed, em[6-i], ea[6-i]);
            end
        end
    endtask

    task automatic test_nonoverlap();
        logic [6:0] s1 = 7'b1101101, e1 = 7'b0001000;
        logic [7:0] s2 = 8'b11011101, e2 = 8'b00010001;
        load(4, 8'b1101, 0);
        for (int i = 0; i < 7; i++) begin
            step(1, s1[6-i], 0);
            n_vec++;
            if (match !== e1[6-i]) begin
                n_err++; $display("FAIL nonovl_a bit%0d: match=%b need %b", i+1, match, e1[6-i]);
            end
        end
        load(4, 8'b1101, 0);
        for (int i = 0; i < 8; i++) begin
            step(1, s2[7-i], 0);
            n_vec++;
            if (match !== e2[7-i]) begin
                n_err++; $display("FAIL nonovl_b bit%0d: match=%b need %b", i+1, match, e2[7-i]);
            end
        end
    endtask

    task automatic test_gaps();
        logic [7:0] s = 8'hA5;
        load(8, 8'hA5, 1);
        for (int i = 0; i < 8; i++) begin
            step(1, s[7-i], 0);
            n_vec++;
            if (match !== (i == 7)) begin
                n_err++; $display("FAIL gaps bit%0d: match=%b need %b", i+1, match, i == 7);
            end
            step(0, 1'($urandom_range(0, 1)), 0);
            n_vec++;
            if (match !== 1'b0) begin
                n_err++; $display("FAIL gaps idle%0d: match=%b need 0", i+1, match);
            end
        end
    endtask

    task automatic test_load_collision();
        logic [3:0] s = 4'b1101, e = 4'b0001;
        load(4, 8'b1101, 1);
        step(1, 1, 0); step(1, 1, 0); step(1, 0, 0);
        step(1, 1, 1);
        n_vec++;
        if (match !== 1'b0 || armed !== 1'b0) begin
            n_err++; $display("FAIL collide: match=%b armed=%b, need 0 0", match, armed);
        end
        for (int i = 0; i < 4; i++) begin
            step(1, s[3-i], 0);
            n_vec++;
            if (match !== e[3-i]) begin
                n_err++; $display("FAIL collide_after bit%0d: match=%b need %b", i+1, match, e[3-i]);
            end
        end
    endtask

    task automatic test_len_clamp();
        logic [2:0] s = 3'b010, e = 3'b001;
        load(0, 8'b10, 1);
        for (int i = 0; i < 3; i++) begin
            step(1, s[2-i], 0);
            n_vec++;
            if (match !== e[2-i]) begin
                n_err++; $display("FAIL clamp_lo bit%0d: match=%b need %b", i+1, match, e[2-i]);
            end
        end
        load(15, 8'h3C, 1);
        for (int i = 0; i < 8; i++) begin
            step(1, (8'h3C >> (7 - i)) & 1, 0);
            n_vec++;
            if (match !== (i == 7) || armed !== (i == 7)) begin
                n_err++; $display("FAIL clamp_hi bit%0d: match=%b armed=%b need %b", i+1, match, armed, i == 7);
            end
        end
    endtask

    task automatic test_midreset();
        logic [3:0] s = 4'b1101;
        load(4, 8'b1101, 1);
        for (int i = 0; i < 4; i++) step(1, s[3-i], 0);
        step(1, 1, 0); step(1, 1, 0); step(1, 0, 0);
        #2 rst_n = 0; model_reset();
        #1;
        n_vec++;
        if (match !== 1'b0 || armed !== 1'b0) begin
            n_err++; $display("FAIL async_reset: match=%b armed=%b, need 0 0", match, armed);
        end
        @(posedge clk); #1 rst_n = 1;
        step(1, 1, 0);
        for (int i = 0; i < 4; i++) step(1, s[3-i], 0);
        n_vec++;
        if (match !== 1'b0 || armed !== 1'b0) begin
            n_err++; $display("FAIL post_reset_idle: match=%b armed=%b, need 0 0", match, armed);
        end
        load(4, 8'b1101, 1);
        for (int i = 0; i < 4; i++) begin
            step(1, s[3-i], 0);
            n_vec++;
            if (match !== (i == 3)) begin
                n_err++; $display("FAIL post_reset_load bit%0d: match=%b need %b", i+1, match, i == 3);
            end
        end
    endtask

    task automatic test_random();
        int r, l;
        load(3, 8'b101, 1);
        for (int n = 0; n < 800; n++) begin
            r = $urandom_range(0, 99);
            if (r < 4) begin
                l = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 4);
                cfg_len = LW'(l); cfg_pattern = ML'($urandom); cfg_overlap = 1'($urandom_range(0, 1));
                step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1);
            end else begin
                step(r < 75, 1'($urandom_range(0, 1)), 0);
            end
            n_vec++;
            if (match !== exp_match || armed !== exp_armed) begin
                n_err++; $display("FAIL random cyc%0d: match=%b armed=%b, need %b %b", n, match, armed, exp_match, exp_armed);
            end
`ifdef SEQDET_MATCH_COUNT_EN
            n_vec++;
            if (match_count !== 2'(exp_cnt)) begin
                n_err++; $display("FAIL random_count cyc%0d: got %0d need %0d", n, match_count, exp_cnt);
            end
`endif
        end
    endtask

`ifdef SEQDET_MATCH_COUNT_EN
    task automatic test_count();
        int ec[6] = '{0, 1, 2, 3, 3, 3};
        pulse_reset();
        load(2, 8'b11, 1);
        for (int i = 0; i < 6; i++) begin
            step(1, 1, 0);
            n_vec++;
            if (match_count !== 2'(ec[i])) begin
                n_err++; $display("FAIL count bit%0d: got %0d need %0d", i+1, match_count, ec[i]);
            end
        end
        load(4, 8'b1101, 1);
        n_vec++;
        if (match_count !== 2'd3) begin
            n_err++; $display("FAIL count_after_load: got %0d need 3", match_count);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_overlap();
        test_nonoverlap();
        test_gaps();
        test_load_collision();
        test_len_clamp();
        test_midreset();
        test_random();
`ifdef SEQDET_MATCH_COUNT_EN
        test_count();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/seq_detector_param.md
SEQ_DETECTOR_PARAM -- requirements
Module: seq_detector_param

Interface
REQ-001 SHALL have parameter MAX_LEN, default 8, giving the maximum pattern length in bits (legal range 2..32).
REQ-002 SHALL have parameter CNT_W, default 8, giving the width of the match counter.
REQ-003 SHALL define LW = $clog2(MAX_LEN)+1 as the width of the length field.
REQ-004 clk  in  1  Single clock; all state changes on its rising edge.
REQ-005 rst_n  in  1  Reset, asynchronous assert, active-low.
REQ-006 in_valid  in  1  Qualifies in_bit; a bit is consumed only on a clk edge with in_valid=1.
REQ-007 in_bit  in  1  Serial input bit.
REQ-008 cfg_load  in  1  Pulse; latches cfg_pattern, cfg_len and cfg_overlap.
REQ-009 cfg_pattern  in  MAX_LEN  Target pattern; bit [len-1] is the oldest (first received) bit and bit [0] the newest.
REQ-010 cfg_len  in  LW  Active pattern length.
REQ-011 cfg_overlap  in  1  1 = overlapping detection; 0 = non-overlapping detection.
REQ-012 match  out  1  Registered one-cycle pulse, high for the cycle following the edge that consumed the final pattern bit.
REQ-013 armed  out  1  High when at least len bits have been consumed since the last flush.
REQ-014 match_count  out  CNT_W  Saturating count of matches (present only with the Configuration macro).

Function
REQ-015 SHALL keep a MAX_LEN-bit history shift register; each consumed bit shifts in at [0].
REQ-016 SHALL keep a fill counter of width LW that increments per consumed bit and saturates at len.
REQ-017 SHALL clamp an effective len of 0 or 1 to 2, and a len above MAX_LEN to MAX_LEN, at cfg_load time.
REQ-018 SHALL declare a match on a consumed bit when both of these hold:
- fill (counting this bit) >= len;
- the low len bits of the updated history equal the low len bits of the stored pattern.
REQ-019 SHALL assert match for exactly one cycle per detected match, with one-edge latency (same edge that consumes the bit).
REQ-020 SHALL hold match at 0 on any edge with in_valid=0.
REQ-021 In overlap mode, history and fill SHALL be retained after a match, so suffix/prefix overlaps are detected.
REQ-022 In non-overlap mode, fill SHALL be cleared to 0 on the matching edge, so the next match needs len fresh bits.
REQ-023 Internal FSM SHALL have states IDLE (no config loaded), FILL (fill<len) and ARMED (fill>=len).
REQ-024 FSM transitions SHALL be:
- IDLE->FILL on cfg_load;
- FILL->ARMED when fill reaches len;
- ARMED->FILL on a non-overlap match;
- any state->FILL on cfg_load.
REQ-025 In IDLE, consumed bits SHALL be ignored and match SHALL stay 0.
REQ-026 cfg_load SHALL clear history and fill.
REQ-027 When cfg_load and in_valid are high on the same edge, load SHALL win and the bit SHALL be discarded.
REQ-028 armed SHALL be registered and SHALL equal (state==ARMED).

Reset
REQ-029 When rst_n=0, the block SHALL asynchronously force:
- state=IDLE, history=0, fill=0;
- pattern=0, len=MAX_LEN, overlap=1;
- match=0, armed=0, match_count=0.
REQ-030 Reset asserted mid-stream SHALL discard partial matches; after release, the block SHALL require cfg_load before detecting.

Configuration
REQ-031 Macro SEQDET_MATCH_COUNT_EN: when defined, match_count SHALL exist, increment on each match, and saturate at 2^CNT_W-1.
REQ-032 match_count SHALL clear on reset only; cfg_load SHALL NOT clear it.
REQ-033 Without SEQDET_MATCH_COUNT_EN, the match_count port and its logic SHALL be absent; all other behaviour SHALL be unchanged.

Verification
REQ-034 len=4, pattern=4'b1101, overlap=1, stream 1101101 -> match after bits 4 and 7; armed from bit 4.
REQ-035 Same config with overlap=0, stream 1101101 -> match after bit 4 only; stream 11011101 -> match after bits 4 and 8.
REQ-036 len=8, pattern=8'hA5, stream with in_valid gaps between bits -> single match after the 8th valid bit; match=0 during gaps.
REQ-037 cfg_load coincident with the final pattern bit -> no match; fill=0; history cleared.
REQ-038 rst_n pulsed low after 3 of 4 pattern bits, then the 4th bit sent -> no match; state IDLE until cfg_load.
REQ-039 With SEQDET_MATCH_COUNT_EN and CNT_W=2, five matches -> match_count sequence 1,2,3,3,3.
